// File: rtl/slave_ram_top.sv
// slave_ram_top: SPI slave front end driving a single-port RAM as a serially addressed memory
module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss_n,
  input  logic                 mosi,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  output logic                 miso
);
  localparam int FW = ADDR_SIZE + 2;
  localparam int CW = $clog2(FW + 1);
  localparam int OW = $clog2(ADDR_SIZE);
  typedef enum logic [1:0] {IDLE, WRITE, READ_ADD, READ_DATA} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [OW-1:0] ocnt;
  logic [ADDR_SIZE-2:0] tx_sh;
  logic rd_addr_received;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // command bit picks the frame type; deselect always returns to idle
  always_comb begin
    state_nxt = ss_n ? IDLE :
                state != IDLE ? state :
                !mosi ? WRITE :
                rd_addr_received ? READ_DATA : READ_ADD;
  end
  // frame shift-in, rx_valid pulse, read flag and miso serialisation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ocnt <= '0;
      tx_sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rd_addr_received <= 1'b0;
      miso <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_n) begin
        cnt <= '0;
        ocnt <= '0;
        miso <= 1'b0;
      end else if (state != IDLE) begin
        if (cnt != CW'(FW)) begin
          rx_data <= {rx_data[FW-2:0], mosi};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(FW - 1)) begin
            rx_valid <= 1'b1;
            if (state == READ_ADD) rd_addr_received <= 1'b1;
          end
        end else if (state == READ_DATA) begin
          if (tx_valid) begin
            miso <= tx_data[ADDR_SIZE-1];
            tx_sh <= tx_data[ADDR_SIZE-2:0];
            ocnt <= OW'(ADDR_SIZE - 1);
          end else if (ocnt != '0) begin
            miso <= tx_sh[ADDR_SIZE-2];
            tx_sh <= {tx_sh[ADDR_SIZE-3:0], 1'b0};
            ocnt <= ocnt - 1'b1;
            if (ocnt == OW'(1)) rd_addr_received <= 1'b0;
          end
        end
      end
    end
endmodule

module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] rx_data,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] tx_data,
  output logic                 tx_valid
);
  logic [ADDR_SIZE-1:0] mem [0:MEM_DEPTH-1];
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, d;
  logic [1:0] op;
  assign op = rx_data[ADDR_SIZE+1:ADDR_SIZE];
  assign d = rx_data[ADDR_SIZE-1:0];
  // address registers and read-data register, decoded from the frame opcode
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= rx_valid && op == 2'b11;
      if (rx_valid && op == 2'b00) wr_addr <= d;
      if (rx_valid && op == 2'b10) rd_addr <= d;
      if (rx_valid && op == 2'b11) tx_data <= mem[rd_addr];
    end
  // storage array is never reset
  always @(posedge clk)
    if (rx_valid && op == 2'b01) mem[wr_addr] <= d;
endmodule

module slave_ram_top #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ss_n,
  input  logic mosi,
  output logic miso
);
  logic [ADDR_SIZE+1:0] rx_data;
  logic [ADDR_SIZE-1:0] tx_data;
  logic rx_valid, tx_valid;
  spi_slave #(.ADDR_SIZE(ADDR_SIZE)) spi_inst (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .rx_data(rx_data), .rx_valid(rx_valid), .miso(miso)
  );
  spi_ram #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) ram_inst (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid)
  );
endmodule

// File: tb/tb_slave_ram_top.sv
// tb_slave_ram_top: randomized frames against a frame-level memory model
module tb_slave_ram_top;
  logic clk = 0, rst_n = 0, ss_n = 1, mosi = 0;
  logic miso;
  logic exp_miso = 0;
  int total = 0, bad = 0;
  logic [7:0] m_mem [256];
  logic [7:0] m_wr = 0, m_rd = 0, last_rd = 0, a;
  bit m_flag = 0;

  slave_ram_top dut (.clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi), .miso(miso));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    total++;
    if (miso !== exp_miso) begin
      bad++;
      $display("FAIL miso t=%0t got=%b want=%b", $time, miso, exp_miso);
    end
  end

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, req);
    end
  endtask

  // low = number of rising edges with ss_n low (1 command + 10 bits + hold)
  task automatic frame(input logic c, input logic [9:0] w, input int low, input bit rmid = 0);
    logic [7:0] b;
    bit out;
    b = m_mem[m_rd];
    out = low >= 11 && c && m_flag && w[9:8] == 2'b11;
    last_rd = 0;
    for (int e = 1; e <= low + 1; e++) begin
      @(negedge clk);
      if (e >= 14 && e <= 21) last_rd = {last_rd[6:0], miso};
      if (e <= low) begin
        ss_n = 0;
        mosi = e == 1 ? c : e <= 11 ? w[11-e] : 1'($urandom_range(0, 1));
        exp_miso = (out && e >= 13) ? b[e >= 20 ? 0 : 20 - e] : 1'b0;
      end
    end
    if (low >= 11) begin
      case (w[9:8])
        2'b00: m_wr = w[7:0];
        2'b01: m_mem[m_wr] = w[7:0];
        2'b10: m_rd = w[7:0];
        default: ;
      endcase
      if (c && !m_flag) m_flag = 1;
      else if (out && low >= 20) m_flag = 0;
    end
    if (rmid) begin
      rst_n = 0;
      ss_n = 1;
      exp_miso = 0;
      #1 check("rst_mid_miso", 32'(miso), 0);
      m_flag = 0;
      m_wr = 0;
      m_rd = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
    end else begin
      ss_n = 1;
      mosi = 0;
      exp_miso = 0;
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic wrrd(input logic [7:0] ad);
    frame(0, {2'b00, ad}, 11 + $urandom_range(0, 2));
    frame(0, {2'b01, 8'hAA}, 11 + $urandom_range(0, 2));
    frame(1, {2'b10, ad}, 11 + $urandom_range(0, 2));
    frame(1, {2'b11, 8'hFF}, 21);
    check("rd_back", 32'(last_rd), 32'h AA);
    check("mem_wr", 32'(dut.ram_inst.mem[ad]), 32'h AA);
  endtask

  task automatic mem_all(input string n);
    for (int i = 0; i < 256; i++) check(n, 32'(dut.ram_inst.mem[i]), 32'(m_mem[i]));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
    m_mem[5] = 8'h5A;
    for (int i = 0; i < 256; i++) dut.ram_inst.mem[i] = m_mem[i];
    repeat (3) @(negedge clk);
    check("reset_miso", 32'(miso), 0);
    rst_n = 1;
    @(negedge clk);
    check("post_reset_miso", 32'(miso), 0);
    wrrd(8'h3C);
    for (int r = 0; r < 7; r++) begin
      do a = 8'($urandom); while (a == 8'h05);
      wrrd(a);
    end
    mem_all("mem_keep");
    frame(1, {2'b10, 8'h05}, 11);
    frame(1, {2'b11, 8'($urandom)}, 21);
    check("pre_rd", 32'(last_rd), 32'h5A);
    frame(0, {2'b01, 8'h11}, 6);
    check("abort_mem", 32'(dut.ram_inst.mem[m_wr]), 32'hAA);
    frame(0, {2'b01, 8'h77}, 11);
    check("after_abort", 32'(dut.ram_inst.mem[m_wr]), 32'h77);
    repeat (60)
      frame(1'($urandom), 10'($urandom),
            $urandom_range(0, 4) == 0 ? 1 + $urandom_range(0, 9) : 11 + $urandom_range(0, 13));
    frame(0, {2'b00, 8'h00}, 11);
    frame(0, {2'b01, 8'hC3}, 11);
    frame(1, {2'b10, 8'h05}, 11);
    frame(1, {2'b11, 8'h00}, 15, 1);
    frame(1, {2'b11, 8'h00}, 21);
    check("post_rst_read_add", 32'(last_rd), 0);
    frame(1, {2'b11, 8'h00}, 21);
    check("post_rst_read", 32'(last_rd), 32'hC3);
    mem_all("mem_final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
